// File: rtl/best_1ofn_busy_pipe.sv
// Pipelined best-1-of-NCHAN CLCT pattern selector with busy masking.
// Optional per-channel dead-time after a win: define BEST1OFN_DEADTIME_EN.
module best_1ofn_busy_pipe #(
    parameter int NCHAN       = 7,
    parameter int MXPATB      = 7,
    parameter int MXKEYB      = 5,
    parameter int MXKEYBX     = 8,
    parameter int MXOFFSB     = 4,
    parameter int MXQLTB      = 6,
    parameter int MXBNDB      = 5,
    parameter int MXPATC      = 12,
    parameter int MXXKYB      = 10,
    parameter int SORT_ON_QLT = 0,
    parameter int SPLIT_KEY   = 128
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_vld,
    input  logic [NCHAN*MXPATB-1:0]     pat,
    input  logic [NCHAN*MXKEYB-1:0]     key,
    input  logic [NCHAN*MXOFFSB-1:0]    offs,
    input  logic [NCHAN*MXQLTB-1:0]     qlt,
    input  logic [NCHAN*MXBNDB-1:0]     bend,
    input  logic [NCHAN*MXPATC-1:0]     carry,
    input  logic [NCHAN-1:0]            bsy,
`ifdef BEST1OFN_DEADTIME_EN
    input  logic [3:0]                  deadtime,
`endif
    output logic                        best_vld,
    output logic [MXPATB-1:0]           best_pat,
    output logic [MXKEYBX-1:0]          best_key,
    output logic [MXXKYB-1:0]           best_subkey,
    output logic [MXQLTB-1:0]           best_qlt,
    output logic [MXBNDB-1:0]           best_bend,
    output logic [MXPATC-1:0]           best_carry,
    output logic                        best_bsy
`ifdef BEST1OFN_DEADTIME_EN
    ,
    output logic [NCHAN-1:0]            chan_dead
`endif
);

    localparam int LVL  = $clog2(NCHAN);
    localparam int NP   = 1 << LVL;
    localparam int IDXB = LVL;
    localparam int SKB  = MXPATB - 1;
    localparam int SW   = MXKEYBX + 4;

    localparam logic signed [SW-1:0] SMAX = SW'((NCHAN << MXKEYB) * 4 - 1);
    localparam logic signed [SW-1:0] SPLO = SW'(4 * SPLIT_KEY - 1);
    localparam logic signed [SW-1:0] SPHI = SW'(4 * SPLIT_KEY);
    localparam logic [MXKEYBX-1:0]   SPK  = MXKEYBX'(SPLIT_KEY);

    typedef struct packed {
        logic                cand;
        logic [SKB-1:0]      sk;
        logic [IDXB-1:0]     idx;
        logic [MXPATB-1:0]   pat;
        logic [MXKEYB-1:0]   key;
        logic [MXOFFSB-1:0]  offs;
        logic [MXQLTB-1:0]   qlt;
        logic [MXBNDB-1:0]   bend;
        logic [MXPATC-1:0]   carry;
    } node_t;

    // Lower index keeps the slot unless the higher one is strictly better.
    function automatic node_t pick(input node_t a, input node_t b);
        node_t r;
        r = a;
        if (b.cand && (!a.cand || (b.sk > a.sk))) r = b;
        return r;
    endfunction

    logic [NCHAN-1:0] dead;

    node_t leaf [NP];
    node_t nd   [1:2*NP-1];
    node_t nd_d [1:NP-1];
    node_t nd_q [1:NP-1];
    node_t root;

    logic [LVL-1:0] vld_d, vld_q;
    logic           rv;

    logic                best_vld_d, best_vld_q;
    logic [MXPATB-1:0]   best_pat_d, best_pat_q;
    logic [MXKEYBX-1:0]  best_key_d, best_key_q;
    logic [MXXKYB-1:0]   best_subkey_d, best_subkey_q;
    logic [MXQLTB-1:0]   best_qlt_d, best_qlt_q;
    logic [MXBNDB-1:0]   best_bend_d, best_bend_q;
    logic [MXPATC-1:0]   best_carry_d, best_carry_q;
    logic                best_bsy_d, best_bsy_q;

    logic [MXKEYBX-1:0]  fk;
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] sc;

    // Unpack channels into tree leaves; padding leaves never compete.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            leaf[i]     = '0;
            leaf[i].idx = IDXB'(i);
        end
        for (int i = 0; i < NCHAN; i++) begin
            leaf[i].cand  = !bsy[i] && !dead[i];
            leaf[i].sk    = (SORT_ON_QLT != 0) ?
                            SKB'(qlt[i*MXQLTB +: MXQLTB]) :
                            pat[i*MXPATB+1 +: SKB];
            leaf[i].pat   = pat[i*MXPATB +: MXPATB];
            leaf[i].key   = key[i*MXKEYB +: MXKEYB];
            leaf[i].offs  = offs[i*MXOFFSB +: MXOFFSB];
            leaf[i].qlt   = qlt[i*MXQLTB +: MXQLTB];
            leaf[i].bend  = bend[i*MXBNDB +: MXBNDB];
            leaf[i].carry = carry[i*MXPATC +: MXPATC];
        end
    end

    // Heap-ordered tree: nodes 1..NP-1 are registered, NP.. are leaves.
    always_comb begin
        for (int k = 1; k < NP; k++) nd[k] = nd_q[k];
        for (int k = 0; k < NP; k++) nd[NP+k] = leaf[k];
        for (int k = 1; k < NP; k++) nd_d[k] = pick(nd[2*k], nd[2*k+1]);
    end

    assign root = nd_q[1];

    // Valid shift pipe aligned with the tree levels.
    always_comb begin
        vld_d[0] = in_vld;
        for (int k = 1; k < LVL; k++) vld_d[k] = vld_q[k-1];
    end

    assign rv = vld_q[LVL-1];

    // Pipeline registers for tree nodes and valid bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 1; k < NP; k++) nd_q[k] <= '0;
            vld_q <= '0;
        end else begin
            for (int k = 1; k < NP; k++) nd_q[k] <= nd_d[k];
            vld_q <= vld_d;
        end
    end

    // Full key, quarter-strip subkey and clamping at the ME1b/ME1a boundary.
    always_comb begin
        fk = MXKEYBX'({root.idx, root.key});
        s  = $signed({2'b00, fk, 2'b00}) + SW'($signed(root.offs));
        sc = s;
        if (sc[SW-1]) sc = '0;
        if (SPLIT_KEY > 0) begin
            if ((fk < SPK) && (sc > SPLO)) sc = SPLO;
            if ((fk >= SPK) && (sc < SPHI)) sc = SPHI;
        end
        if (sc > SMAX) sc = SMAX;
    end

    // Output stage: load on valid, otherwise hold the last winner.
    always_comb begin
        best_vld_d    = rv;
        best_pat_d    = best_pat_q;
        best_key_d    = best_key_q;
        best_subkey_d = best_subkey_q;
        best_qlt_d    = best_qlt_q;
        best_bend_d   = best_bend_q;
        best_carry_d  = best_carry_q;
        best_bsy_d    = best_bsy_q;
        if (rv) begin
            if (root.cand) begin
                best_pat_d    = root.pat;
                best_key_d    = fk;
                best_subkey_d = sc[MXXKYB-1:0];
                best_qlt_d    = root.qlt;
                best_bend_d   = root.bend;
                best_carry_d  = root.carry;
                best_bsy_d    = 1'b0;
            end else begin
                best_pat_d    = '0;
                best_key_d    = '0;
                best_subkey_d = '0;
                best_qlt_d    = '0;
                best_bend_d   = '0;
                best_carry_d  = '0;
                best_bsy_d    = 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            best_vld_q    <= 1'b0;
            best_pat_q    <= '0;
            best_key_q    <= '0;
            best_subkey_q <= '0;
            best_qlt_q    <= '0;
            best_bend_q   <= '0;
            best_carry_q  <= '0;
            best_bsy_q    <= 1'b0;
        end else begin
            best_vld_q    <= best_vld_d;
            best_pat_q    <= best_pat_d;
            best_key_q    <= best_key_d;
            best_subkey_q <= best_subkey_d;
            best_qlt_q    <= best_qlt_d;
            best_bend_q   <= best_bend_d;
            best_carry_q  <= best_carry_d;
            best_bsy_q    <= best_bsy_d;
        end
    end

    assign best_vld    = best_vld_q;
    assign best_pat    = best_pat_q;
    assign best_key    = best_key_q;
    assign best_subkey = best_subkey_q;
    assign best_qlt    = best_qlt_q;
    assign best_bend   = best_bend_q;
    assign best_carry  = best_carry_q;
    assign best_bsy    = best_bsy_q;

`ifdef BEST1OFN_DEADTIME_EN
    logic [3:0] cnt_d [NCHAN];
    logic [3:0] cnt_q [NCHAN];
    logic       win_ld;

    assign win_ld = rv && root.cand;

    // Reload the winner's counter as its result registers, else count down.
    always_comb begin
        for (int i = 0; i < NCHAN; i++) begin
            dead[i]  = (cnt_q[i] != 4'd0);
            cnt_d[i] = cnt_q[i];
            if (win_ld && (root.idx == IDXB'(i))) begin
                cnt_d[i] = deadtime;
            end else if (dead[i]) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
        end
    end

    // Dead-time counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCHAN; i++) cnt_q[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NCHAN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign chan_dead = dead;
`else
    assign dead = '0;
`endif

endmodule

// File: tb/tb_best_1ofn_busy_pipe.sv
// Directed bench for best_1ofn_busy_pipe (NCHAN=7 defaults).
// Dead-time scenario runs only when BEST1OFN_DEADTIME_EN is defined.
module tb_best_1ofn_busy_pipe;

    localparam int NCHAN   = 7;
    localparam int MXPATB  = 7;
    localparam int MXKEYB  = 5;
    localparam int MXKEYBX = 8;
    localparam int MXOFFSB = 4;
    localparam int MXQLTB  = 6;
    localparam int MXBNDB  = 5;
    localparam int MXPATC  = 12;
    localparam int MXXKYB  = 10;

    logic clock = 1'b0;
    logic reset;
    logic in_vld;
    logic [NCHAN*MXPATB-1:0]  pat;
    logic [NCHAN*MXKEYB-1:0]  key;
    logic [NCHAN*MXOFFSB-1:0] offs;
    logic [NCHAN*MXQLTB-1:0]  qlt;
    logic [NCHAN*MXBNDB-1:0]  bend;
    logic [NCHAN*MXPATC-1:0]  carry;
    logic [NCHAN-1:0]         bsy;
    logic                     best_vld;
    logic [MXPATB-1:0]        best_pat;
    logic [MXKEYBX-1:0]       best_key;
    logic [MXXKYB-1:0]        best_subkey;
    logic [MXQLTB-1:0]        best_qlt;
    logic [MXBNDB-1:0]        best_bend;
    logic [MXPATC-1:0]        best_carry;
    logic                     best_bsy;
`ifdef BEST1OFN_DEADTIME_EN
    logic [3:0]               deadtime;
    logic [NCHAN-1:0]         chan_dead;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    best_1ofn_busy_pipe dut (
        .clock(clock),
        .reset(reset),
        .in_vld(in_vld),
        .pat(pat),
        .key(key),
        .offs(offs),
        .qlt(qlt),
        .bend(bend),
        .carry(carry),
        .bsy(bsy),
`ifdef BEST1OFN_DEADTIME_EN
        .deadtime(deadtime),
`endif
        .best_vld(best_vld),
        .best_pat(best_pat),
        .best_key(best_key),
        .best_subkey(best_subkey),
        .best_qlt(best_qlt),
        .best_bend(best_bend),
        .best_carry(best_carry),
        .best_bsy(best_bsy)
`ifdef BEST1OFN_DEADTIME_EN
        ,
        .chan_dead(chan_dead)
`endif
    );

    // Channel c: qlt=c+10, bend=c+1, carry=0x100+c.
    task automatic set_ch(input int c, input logic [5:0] sk,
                          input logic [4:0] k, input logic [3:0] o);
        pat[c*MXPATB +: MXPATB]    = {sk, 1'b1};
        key[c*MXKEYB +: MXKEYB]    = k;
        offs[c*MXOFFSB +: MXOFFSB] = o;
        qlt[c*MXQLTB +: MXQLTB]    = 6'(c + 10);
        bend[c*MXBNDB +: MXBNDB]   = 5'(c + 1);
        carry[c*MXPATC +: MXPATC]  = 12'h100 + 12'(c);
    endtask

    task automatic set_keys(input logic [5:0] s0, input logic [5:0] s1,
                            input logic [5:0] s2, input logic [5:0] s3,
                            input logic [5:0] s4, input logic [5:0] s5,
                            input logic [5:0] s6);
        set_ch(0, s0, 5'd10, 4'd0);
        set_ch(1, s1, 5'd11, 4'd0);
        set_ch(2, s2, 5'd12, 4'd0);
        set_ch(3, s3, 5'd13, 4'd0);
        set_ch(4, s4, 5'd14, 4'd0);
        set_ch(5, s5, 5'd15, 4'd0);
        set_ch(6, s6, 5'd16, 4'd0);
    endtask

    task automatic send_one(input logic [NCHAN-1:0] b, output int lat);
        @(negedge clock);
        bsy    = b;
        in_vld = 1'b1;
        @(negedge clock);
        in_vld = 1'b0;
        lat = 1;
        while (!best_vld && lat < 12) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++;
        if (best_vld !== 1'b0 || best_key !== '0 || best_bsy !== 1'b0 ||
            best_subkey !== '0 || best_pat !== '0 || best_carry !== '0) begin
            errors++;
            $display("FAIL reset_state: vld=%b key=%0d bsy=%b sub=%0d want all 0",
                     best_vld, best_key, best_bsy, best_subkey);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        set_keys(6'd5, 6'd9, 6'd9, 6'd3, 6'd0, 6'd0, 6'd0);
        send_one(7'h00, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        checks++;
        if (best_vld !== 1'b1 || best_bsy !== 1'b0 || best_key !== 8'd43) begin
            errors++;
            $display("FAIL basic_key: vld=%b bsy=%b key=%0d want 1 0 43",
                     best_vld, best_bsy, best_key);
        end
        checks++;
        if (best_pat !== 7'h13 || best_subkey !== 10'd172 ||
            best_qlt !== 6'd11 || best_bend !== 5'd2 ||
            best_carry !== 12'h101) begin
            errors++;
            $display("FAIL basic_fields: pat=%h sub=%0d qlt=%0d bend=%0d carry=%h want 13 172 11 2 101",
                     best_pat, best_subkey, best_qlt, best_bend, best_carry);
        end
        @(negedge clock);
        checks++;
        if (best_vld !== 1'b0 || best_key !== 8'd43) begin
            errors++;
            $display("FAIL basic_hold: vld=%b key=%0d want 0 43", best_vld, best_key);
        end
    endtask

    task automatic test_busy_mask;
        int lat;
        set_keys(6'd5, 6'd9, 6'd9, 6'd3, 6'd0, 6'd0, 6'd0);
        send_one(7'b0000010, lat);
        checks++;
        if (lat !== 4 || best_key !== 8'd76 || best_pat !== 7'h13 ||
            best_subkey !== 10'd304 || best_qlt !== 6'd12) begin
            errors++;
            $display("FAIL busy_mask: lat=%0d key=%0d pat=%h sub=%0d qlt=%0d want 4 76 13 304 12",
                     lat, best_key, best_pat, best_subkey, best_qlt);
        end
    endtask

    task automatic test_all_busy;
        int lat;
        send_one(7'h7F, lat);
        checks++;
        if (lat !== 4 || best_vld !== 1'b1 || best_bsy !== 1'b1) begin
            errors++;
            $display("FAIL all_busy_flag: lat=%0d vld=%b bsy=%b want 4 1 1",
                     lat, best_vld, best_bsy);
        end
        checks++;
        if (best_pat !== '0 || best_key !== '0 || best_subkey !== '0 ||
            best_qlt !== '0 || best_bend !== '0 || best_carry !== '0) begin
            errors++;
            $display("FAIL all_busy_zero: pat=%h key=%0d sub=%0d qlt=%0d bend=%0d carry=%h want 0",
                     best_pat, best_key, best_subkey, best_qlt, best_bend, best_carry);
        end
    endtask

    task automatic test_tie;
        int lat;
        set_keys(6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7);
        send_one(7'h00, lat);
        checks++;
        if (best_key !== 8'd10 || best_pat !== 7'h0F || best_bsy !== 1'b0) begin
            errors++;
            $display("FAIL tie_lowest: key=%0d pat=%h bsy=%b want 10 0f 0",
                     best_key, best_pat, best_bsy);
        end
    endtask

    task automatic test_subkey;
        int lat;
        int          ch   [6] = '{0, 3, 3, 6, 4, 4};
        logic [4:0]  kk   [6] = '{5'd0, 5'd31, 5'd31, 5'd31, 5'd0, 5'd0};
        logic [3:0]  oo   [6] = '{4'hD, 4'd5, 4'hF, 4'd7, 4'hE, 4'd3};
        logic [7:0]  ek   [6] = '{8'd0, 8'd127, 8'd127, 8'd223, 8'd128, 8'd128};
        logic [9:0]  es   [6] = '{10'd0, 10'd511, 10'd507, 10'd895, 10'd512, 10'd515};
        for (int n = 0; n < 6; n++) begin
            set_keys(6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1);
            set_ch(ch[n], 6'd2, kk[n], oo[n]);
            send_one(~(7'(1) << ch[n]), lat);
            checks++;
            if (lat !== 4 || best_key !== ek[n] || best_subkey !== es[n]) begin
                errors++;
                $display("FAIL subkey_%0d: lat=%0d key=%0d sub=%0d want 4 %0d %0d",
                         n, lat, best_key, best_subkey, ek[n], es[n]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [NCHAN-1:0] bq [3] = '{7'b1110111, 7'h7F, 7'b0111111};
        set_keys(6'd4, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4);
        for (int t = 0; t < 8; t++) begin
            @(negedge clock);
            if (t == 4) begin
                checks++;
                if (best_vld !== 1'b1 || best_bsy !== 1'b0 || best_key !== 8'd109) begin
                    errors++;
                    $display("FAIL b2b_a: vld=%b bsy=%b key=%0d want 1 0 109",
                             best_vld, best_bsy, best_key);
                end
            end
            if (t == 5) begin
                checks++;
                if (best_vld !== 1'b1 || best_bsy !== 1'b1 || best_key !== 8'd0) begin
                    errors++;
                    $display("FAIL b2b_c: vld=%b bsy=%b key=%0d want 1 1 0",
                             best_vld, best_bsy, best_key);
                end
            end
            if (t == 6) begin
                checks++;
                if (best_vld !== 1'b1 || best_bsy !== 1'b0 || best_key !== 8'd208) begin
                    errors++;
                    $display("FAIL b2b_b: vld=%b bsy=%b key=%0d want 1 0 208",
                             best_vld, best_bsy, best_key);
                end
            end
            if (t == 7) begin
                checks++;
                if (best_vld !== 1'b0 || best_key !== 8'd208 || best_bsy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_hold: vld=%b key=%0d bsy=%b want 0 208 0",
                             best_vld, best_key, best_bsy);
                end
            end
            if (t < 3) begin
                in_vld = 1'b1;
                bsy    = bq[t];
            end else begin
                in_vld = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midstream;
        int lat;
        int seen;
        set_keys(6'd4, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4);
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            in_vld = 1'b1;
            bsy    = 7'b1110111;
        end
        @(negedge clock);
        in_vld = 1'b0;
        reset  = 1'b1;
        #1;
        checks++;
        if (best_vld !== 1'b0 || best_key !== '0 || best_subkey !== '0 ||
            best_qlt !== '0 || best_bsy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: vld=%b key=%0d sub=%0d qlt=%0d bsy=%b want 0",
                     best_vld, best_key, best_subkey, best_qlt, best_bsy);
        end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clock);
            if (best_vld) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_flush: valid outputs seen %0d want 0", seen);
        end
        send_one(7'b1111101, lat);
        checks++;
        if (lat !== 4 || best_key !== 8'd43) begin
            errors++;
            $display("FAIL rst_mid_resume: lat=%0d key=%0d want 4 43", lat, best_key);
        end
        repeat (3) @(negedge clock);
    endtask

`ifdef BEST1OFN_DEADTIME_EN
    task automatic test_deadtime;
        int expc [8] = '{5, -1, -1, -1, 0, 0, 0, 5};
        int k;
        set_keys(6'd15, 6'd1, 6'd1, 6'd1, 6'd1, 6'd20, 6'd1);
        deadtime = 4'd3;
        for (int t = 0; t < 12; t++) begin
            @(negedge clock);
            if (t >= 4) begin
                k = t - 4;
                checks++;
                if (expc[k] < 0) begin
                    if (best_vld !== 1'b1 || best_bsy !== 1'b1) begin
                        errors++;
                        $display("FAIL dead_item%0d: vld=%b bsy=%b want 1 1",
                                 k, best_vld, best_bsy);
                    end
                end else if (best_vld !== 1'b1 || best_bsy !== 1'b0 ||
                             best_key[7:5] !== 3'(expc[k])) begin
                    errors++;
                    $display("FAIL dead_item%0d: vld=%b bsy=%b chan=%0d want 1 0 %0d",
                             k, best_vld, best_bsy, best_key[7:5], expc[k]);
                end
            end
            if (t == 4 || t == 6) begin
                checks++;
                if (chan_dead !== 7'b0100000) begin
                    errors++;
                    $display("FAIL dead_mask_t%0d: got %b want 0100000", t, chan_dead);
                end
            end
            if (t == 7) begin
                checks++;
                if (chan_dead !== 7'b0000000) begin
                    errors++;
                    $display("FAIL dead_mask_t7: got %b want 0000000", chan_dead);
                end
            end
            if (t < 8) begin
                in_vld = 1'b1;
                bsy    = (t >= 1 && t <= 3) ? 7'h7F : 7'h00;
            end else begin
                in_vld = 1'b0;
            end
        end
        deadtime = 4'd0;
        repeat (16) @(negedge clock);
    endtask
`endif

    initial begin
        reset  = 1'b1;
        in_vld = 1'b0;
        pat    = '0;
        key    = '0;
        offs   = '0;
        qlt    = '0;
        bend   = '0;
        carry  = '0;
        bsy    = '0;
`ifdef BEST1OFN_DEADTIME_EN
        deadtime = 4'd0;
`endif
        repeat (3) @(negedge clock);
        test_reset;
        repeat (2) @(negedge clock);
        test_basic;
        test_busy_mask;
        test_all_busy;
        test_tie;
        test_subkey;
        test_back_to_back;
        test_reset_midstream;
`ifdef BEST1OFN_DEADTIME_EN
        test_deadtime;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
